// File: rtl/frc_timer_if.sv
// I/O-space register bus between the CPU address decoder (master) and a peripheral (slave).
interface frc_timer_if;
    localparam int unsigned ADR_W = 3;
    localparam int unsigned DAT_W = 32;

    logic             io_sel;
    logic             io_we;
    logic [ADR_W-1:0] io_adr;
    logic [DAT_W-1:0] io_wdata;
    logic [DAT_W-1:0] io_rdata;

    modport master (
        output io_sel,
        output io_we,
        output io_adr,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_sel,
        input  io_we,
        input  io_adr,
        input  io_wdata,
        output io_rdata
    );
endinterface

// File: rtl/frc_timer.sv
// Free-running prescaled 32-bit timer with compare, optional auto-reload and a W1C match flag.
// Drives the core's only interrupt line plus a one-cycle clear pulse for its edge latch.
module frc_timer #(
    parameter int unsigned PRE_W   = 16,
    parameter logic [31:0] CMP_RST = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    frc_timer_if.slave   io,
    output logic         interrupt_0,
    output logic         interrupt_clear
);

    localparam int unsigned DAT_W = 32;
    localparam int unsigned ADR_W = 3;

    localparam logic [ADR_W-1:0] ADR_CTRL     = 3'd0;
    localparam logic [ADR_W-1:0] ADR_PRESCALE = 3'd1;
    localparam logic [ADR_W-1:0] ADR_COUNT    = 3'd2;
    localparam logic [ADR_W-1:0] ADR_CMP      = 3'd3;
    localparam logic [ADR_W-1:0] ADR_STATUS   = 3'd4;

    // Architectural state
    logic             en_q;
    logic             reload_q;
    logic             irq_en_q;
    logic [PRE_W-1:0] prescale_q;
    logic [PRE_W-1:0] pre_cnt_q;
    logic [DAT_W-1:0] count_q;
    logic [DAT_W-1:0] cmp_q;
    logic             match_q;
    logic [DAT_W-1:0] rdata_q;
    logic             irq_q;
    logic             irq_clr_q;

    // Next-state values
    logic             en_d;
    logic             reload_d;
    logic             irq_en_d;
    logic [PRE_W-1:0] prescale_d;
    logic [PRE_W-1:0] pre_cnt_d;
    logic [DAT_W-1:0] count_d;
    logic [DAT_W-1:0] cmp_d;
    logic             match_d;
    logic [DAT_W-1:0] rdata_d;
    logic             irq_d;
    logic             irq_clr_d;

    // Decoded strobes and datapath helpers
    logic             wr_c;
    logic             rd_c;
    logic             ctrl_we_c;
    logic             prescale_we_c;
    logic             count_we_c;
    logic             cmp_we_c;
    logic             clear_req_c;
    logic             tick_c;
    logic             match_set_c;
    logic [DAT_W-1:0] count_inc_c;
    logic [DAT_W-1:0] rd_mux_c;

    // Bus decode, prescaler tick and compare
    always_comb begin
        wr_c          = io.io_sel & io.io_we;
        rd_c          = io.io_sel & ~io.io_we;
        ctrl_we_c     = wr_c && (io.io_adr == ADR_CTRL);
        prescale_we_c = wr_c && (io.io_adr == ADR_PRESCALE);
        count_we_c    = wr_c && (io.io_adr == ADR_COUNT);
        cmp_we_c      = wr_c && (io.io_adr == ADR_CMP);
        clear_req_c   = wr_c && (io.io_adr == ADR_STATUS) && io.io_wdata[0];
        tick_c        = en_q && (pre_cnt_q == prescale_q);
        // A COUNT write overrides the tick, so no compare is evaluated that cycle
        match_set_c   = tick_c && !count_we_c && (count_q == cmp_q);
        count_inc_c   = count_q + DAT_W'(1);
    end

    // Read mux reflects current (pre-update) register values
    always_comb begin
        rd_mux_c = '0;
        case (io.io_adr)
            ADR_CTRL:     rd_mux_c = {29'd0, irq_en_q, reload_q, en_q};
            ADR_PRESCALE: rd_mux_c = DAT_W'(prescale_q);
            ADR_COUNT:    rd_mux_c = count_q;
            ADR_CMP:      rd_mux_c = cmp_q;
            ADR_STATUS:   rd_mux_c = {31'd0, match_q};
            default:      rd_mux_c = '0;
        endcase
    end

    // Next-state logic for all registers
    always_comb begin
        en_d       = en_q;
        reload_d   = reload_q;
        irq_en_d   = irq_en_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        count_d    = count_q;
        cmp_d      = cmp_q;
        match_d    = match_q;
        rdata_d    = rdata_q;
        irq_d      = 1'b0;
        irq_clr_d  = 1'b0;

        if (ctrl_we_c) begin
            en_d     = io.io_wdata[0];
            reload_d = io.io_wdata[1];
            irq_en_d = io.io_wdata[2];
        end
        if (prescale_we_c) begin
            prescale_d = io.io_wdata[PRE_W-1:0];
        end
        if (cmp_we_c) begin
            cmp_d = io.io_wdata;
        end

        if (!en_q || prescale_we_c || count_we_c || tick_c) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        if (count_we_c) begin
            count_d = io.io_wdata;
        end else if (tick_c) begin
            count_d = (match_set_c && reload_q) ? '0 : count_inc_c;
        end

        // Set wins over a same-cycle clear
        if (match_set_c) begin
            match_d = 1'b1;
        end else if (clear_req_c) begin
            match_d = 1'b0;
        end

        // Forcing the level low during a clear guarantees a new rising edge downstream
        irq_d     = match_d & irq_en_q & ~clear_req_c;
        irq_clr_d = clear_req_c;

        if (rd_c) begin
            rdata_d = rd_mux_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            reload_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            count_q    <= '0;
            cmp_q      <= CMP_RST;
            match_q    <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
            irq_clr_q  <= 1'b0;
        end else begin
            en_q       <= en_d;
            reload_q   <= reload_d;
            irq_en_q   <= irq_en_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
            irq_clr_q  <= irq_clr_d;
        end
    end

    assign io.io_rdata     = rdata_q;
    assign interrupt_0     = irq_q;
    assign interrupt_clear = irq_clr_q;

endmodule

// File: tb/tb_frc_timer.sv
// Directed bench for frc_timer: a per-cycle vector table plus hand sequences for multi-cycle corners.
module tb_frc_timer;

    logic clk;
    logic rst_n;
    logic irq;
    logic clr;

    frc_timer_if bus ();

    frc_timer #(.PRE_W(16), .CMP_RST(32'hFFFF_FFFF)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .io              (bus),
        .interrupt_0     (irq),
        .interrupt_clear (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        we;
        logic [2:0]  adr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_irq;
        logic        exp_clr;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t rv(input logic [2:0] adr, input logic [31:0] er,
                                input logic ei, input logic ec);
        vec_t v;
        v = '{1'b1, 1'b0, adr, 32'd0, er, ei, ec};
        return v;
    endfunction

    function automatic vec_t wv(input logic [2:0] adr, input logic [31:0] wd,
                                input logic [31:0] er, input logic ei, input logic ec);
        vec_t v;
        v = '{1'b1, 1'b1, adr, wd, er, ei, ec};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle; outputs are then sampled 1 time unit after the edge
    task automatic step(input logic sel, input logic we, input logic [2:0] adr, input logic [31:0] wd);
        bus.io_sel   = sel;
        bus.io_we    = we;
        bus.io_adr   = adr;
        bus.io_wdata = wd;
        @(posedge clk);
        #1;
        bus.io_sel = 1'b0;
        bus.io_we  = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [31:0] wd);
        step(1'b1, 1'b1, adr, wd);
    endtask

    task automatic rd(input logic [2:0] adr);
        step(1'b1, 1'b0, adr, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [31:0] exp_cnt;

    initial begin
        rst_n        = 1'b0;
        bus.io_sel   = 1'b0;
        bus.io_we    = 1'b0;
        bus.io_adr   = 3'd0;
        bus.io_wdata = 32'd0;

        // Periodic reload/IRQ flow, W1C, IRQ_EN gating, reset register values
        vecs[0]  = rv(3'd0, 32'h0000_0000, 1'b0, 1'b0);
        vecs[1]  = rv(3'd3, 32'hFFFF_FFFF, 1'b0, 1'b0);
        vecs[2]  = rv(3'd5, 32'h0000_0000, 1'b0, 1'b0);
        vecs[3]  = rv(3'd1, 32'h0000_0000, 1'b0, 1'b0);
        vecs[4]  = wv(3'd1, 32'd0, 32'h0, 1'b0, 1'b0);
        vecs[5]  = wv(3'd3, 32'd5, 32'h0, 1'b0, 1'b0);
        vecs[6]  = wv(3'd0, 32'd7, 32'h0, 1'b0, 1'b0);
        vecs[7]  = rv(3'd2, 32'd0, 1'b0, 1'b0);
        vecs[8]  = rv(3'd2, 32'd1, 1'b0, 1'b0);
        vecs[9]  = rv(3'd2, 32'd2, 1'b0, 1'b0);
        vecs[10] = rv(3'd2, 32'd3, 1'b0, 1'b0);
        vecs[11] = rv(3'd2, 32'd4, 1'b0, 1'b0);
        vecs[12] = rv(3'd2, 32'd5, 1'b1, 1'b0);
        vecs[13] = rv(3'd2, 32'd0, 1'b1, 1'b0);
        vecs[14] = rv(3'd4, 32'd1, 1'b1, 1'b0);
        vecs[15] = wv(3'd4, 32'd1, 32'd1, 1'b0, 1'b1);
        vecs[16] = rv(3'd2, 32'd3, 1'b0, 1'b0);
        vecs[17] = rv(3'd2, 32'd4, 1'b0, 1'b0);
        vecs[18] = rv(3'd2, 32'd5, 1'b1, 1'b0);
        vecs[19] = wv(3'd4, 32'd0, 32'd5, 1'b1, 1'b0);
        vecs[20] = rv(3'd4, 32'd1, 1'b1, 1'b0);
        vecs[21] = wv(3'd0, 32'd0, 32'd1, 1'b1, 1'b0);
        vecs[22] = rv(3'd2, 32'd3, 1'b0, 1'b0);
        vecs[23] = rv(3'd2, 32'd3, 1'b0, 1'b0);
        vecs[24] = rv(3'd0, 32'd0, 1'b0, 1'b0);
        vecs[25] = wv(3'd4, 32'd1, 32'd0, 1'b0, 1'b1);
        vecs[26] = rv(3'd4, 32'd0, 1'b0, 1'b0);

        #3;
        chk("reset_rdata", bus.io_rdata, 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_clr", 32'(clr), 32'd0);
        #9;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].sel, vecs[i].we, vecs[i].adr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), bus.io_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].exp_irq));
            chk($sformatf("vec%0d_clr", i), 32'(clr), 32'(vecs[i].exp_clr));
        end

        // Prescale: PRESCALE=3, CMP=2, EN+IRQ_EN, no reload
        do_reset();
        wr(3'd1, 32'd3);
        wr(3'd3, 32'd2);
        wr(3'd0, 32'd5);
        for (int k = 1; k <= 16; k++) begin
            rd(3'd2);
            chk($sformatf("pre_count_k%0d", k), bus.io_rdata, 32'((k - 1) / 4));
            chk($sformatf("pre_irq_k%0d", k), 32'(irq), (k >= 12) ? 32'd1 : 32'd0);
        end

        // Wrap: COUNT=FFFF_FFFE, CMP=1, EN only
        do_reset();
        wr(3'd2, 32'hFFFF_FFFE);
        wr(3'd3, 32'd1);
        wr(3'd0, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            rd(3'd2);
            exp_cnt = 32'hFFFF_FFFE + 32'(k - 1);
            chk($sformatf("wrap_count_k%0d", k), bus.io_rdata, exp_cnt);
        end
        chk("wrap_irq_gated", 32'(irq), 32'd0);
        rd(3'd4);
        chk("wrap_match", bus.io_rdata, 32'd1);
        wr(3'd0, 32'd5);
        idle();
        chk("irq_en_late", 32'(irq), 32'd1);
        wr(3'd4, 32'd1);
        chk("w1c_irq", 32'(irq), 32'd0);
        chk("w1c_clr", 32'(clr), 32'd1);
        idle();
        chk("w1c_clr_once", 32'(clr), 32'd0);
        chk("w1c_irq_stay", 32'(irq), 32'd0);
        rd(3'd4);
        chk("w1c_status", bus.io_rdata, 32'd0);

        // Collision: match tick and STATUS clear on the same edge
        do_reset();
        wr(3'd3, 32'd3);
        wr(3'd0, 32'd7);
        idle();
        idle();
        idle();
        wr(3'd4, 32'd1);
        chk("coll_irq_low", 32'(irq), 32'd0);
        chk("coll_clr", 32'(clr), 32'd1);
        rd(3'd4);
        chk("coll_match_kept", bus.io_rdata, 32'd1);
        chk("coll_irq_high", 32'(irq), 32'd1);
        chk("coll_clr_once", 32'(clr), 32'd0);

        // Asynchronous reset with a clear pulse in flight
        wr(3'd4, 32'd1);
        chk("prerst_clr", 32'(clr), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("rst_rdata", bus.io_rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_clr", 32'(clr), 32'd0);
        rst_n = 1'b1;
        idle();
        chk("rst_clr_dropped", 32'(clr), 32'd0);
        rd(3'd3);
        chk("rst_cmp", bus.io_rdata, 32'hFFFF_FFFF);
        rd(3'd5);
        chk("rd_adr5", bus.io_rdata, 32'd0);
        rd(3'd3);
        rd(3'd6);
        chk("rd_adr6", bus.io_rdata, 32'd0);
        rd(3'd3);
        rd(3'd7);
        chk("rd_adr7", bus.io_rdata, 32'd0);
        rd(3'd3);
        rd(3'd2);
        chk("rst_count", bus.io_rdata, 32'd0);

        // COUNT write coincident with a matching tick
        do_reset();
        wr(3'd3, 32'd2);
        wr(3'd0, 32'd1);
        idle();
        idle();
        wr(3'd2, 32'h0000_0100);
        rd(3'd2);
        chk("wrprio_count", bus.io_rdata, 32'h0000_0100);
        rd(3'd4);
        chk("wrprio_nomatch", bus.io_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
